rf_seq: RTL and testbench
=========================

RF_SEQ -- requirements
Module: rf_seq

Interface
REQ-001 Parameter DW, default 8, data bus width.
REQ-002 Parameter NREG, default 5, number of register-file targets (index 0..4 = A,B,C,D,F).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at rising edge.
REQ-007 cmd_op  input  2  00 NOP, 01 MOV, 10 LDI, 11 RD.
REQ-008 cmd_src  input  3  source register index.
REQ-009 cmd_dst  input  3  destination register index.
REQ-010 cmd_imm  input  DW  immediate for LDI.
REQ-011 ld  output  NREG  one-hot register load enables, to the register file's input enables.
REQ-012 oe  output  NREG  one-hot register output enables, to the register file's output enables.
REQ-013 d  output  DW  bus data driven into the register file.
REQ-014 p  input  DW  register-file bus readback.
REQ-015 rd_data  output  DW  captured readback.
REQ-016 rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-017 err  output  1  one-cycle pulse, illegal register index.

Function
REQ-018 States IDLE, SETUP, XFER; all outputs registered.
REQ-019 IDLE: cmd_ready=1; on handshake latch op/src/dst/imm, go SETUP; NOP returns to IDLE with no enables asserted.
REQ-020 Any latched index >= NREG used by the op: err pulses in SETUP cycle, no ld/oe asserted, next state IDLE.
REQ-021 MOV: SETUP oe[src]=1; XFER oe[src]=1 and ld[dst]=1; then IDLE; latency handshake->ld = 2 cycles.
REQ-022 MOV with src==dst: no-op, no enables, no err, returns to IDLE after SETUP.
REQ-023 LDI: SETUP d=imm, oe=0; XFER d=imm, ld[dst]=1; then IDLE.
REQ-024 RD: SETUP oe[src]=1; XFER oe[src]=1, rd_data<=p at end of XFER, rd_valid pulses the following cycle.
REQ-025 d=0 whenever no LDI in progress; at most one ld bit and one oe bit set in any cycle; ld and oe never both address the same register.
REQ-026 cmd_ready=0 in SETUP and XFER (unless REQ-030).

Reset
REQ-027 rst_n low asynchronously forces IDLE, ld=0, oe=0, d=0, rd_data=0, rd_valid=0, err=0, cmd_ready=0 while asserted.
REQ-028 cmd_ready rises the first cycle after rst_n deassertion; reset mid-command abandons it, no partial ld after release.

Configuration
REQ-029 Macro RF_SEQ_BURST_EN selects back-to-back issue.
REQ-030 With RF_SEQ_BURST_EN: cmd_ready=1 also in XFER; handshake there goes directly to SETUP of the new command (one command per 2 cycles).
REQ-031 Without RF_SEQ_BURST_EN: XFER always returns to IDLE (one command per 3 cycles).

Structure
REQ-032 Shared package holds op encodings, state encoding, and register index constants REG_A..REG_F.
REQ-033 One sub-module rf_seq_dec: index -> one-hot NREG decoder with out-of-range flag, instanced for src and dst.

Verification
REQ-034 LDI dst=A imm=100 -> SETUP d=100, XFER ld=00001 d=100, then all zero.
REQ-035 MOV src=A dst=B -> oe=00001 two cycles, ld=00010 in second; cmd_ready low 2 cycles.
REQ-036 RD src=C with p=64 -> oe=00100 two cycles, rd_valid pulse with rd_data=64.
REQ-037 MOV src=6 dst=A -> err one pulse, ld=oe=0, ready again next cycle.
REQ-038 rst_n low during XFER of LDI -> ld, d clear immediately; after release rf unchanged, cmd_ready=1.
REQ-039 Two LDIs back-to-back -> ld pulses spaced 2 cycles with RF_SEQ_BURST_EN, 3 without.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: op codes, FSM states and register index names shared
// by the sequencer, its index decoder and the bench.
package rf_seq_pkg;

  localparam int IW = 3;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_MOV = 2'b01,
    OP_LDI = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_XFER  = 2'b10
  } state_e;

  localparam logic [IW-1:0] REG_A = 3'd0;
  localparam logic [IW-1:0] REG_B = 3'd1;
  localparam logic [IW-1:0] REG_C = 3'd2;
  localparam logic [IW-1:0] REG_D = 3'd3;
  localparam logic [IW-1:0] REG_F = 3'd4;

  function automatic logic uses_src(input op_e op);
    return (op == OP_MOV) || (op == OP_RD);
  endfunction

  function automatic logic uses_dst(input op_e op);
    return (op == OP_MOV) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/rf_seq_dec.sv
// rf_seq_dec: register index -> one-hot enable vector.
// Ports: idx in, oh one-hot out (zero if out of range), bad flag.
module rf_seq_dec
  import rf_seq_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  oh,
  output logic          bad
);

  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) begin
      oh[i] = (idx == IW'(i));
    end
    bad = ({1'b0, idx} >= 4'(N));
  end

endmodule

// File: rtl/rf_seq.sv
// rf_seq: register-file transfer sequencer (NOP/MOV/LDI/RD), IDLE/SETUP/XFER.
// Ports: cmd_* handshake in; ld/oe/d to rf, p readback, rd_data/rd_valid/err.
// Define RF_SEQ_BURST_EN to accept a new command while in XFER.
module rf_seq
  import rf_seq_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IW-1:0]   cmd_src,
  input  logic [IW-1:0]   cmd_dst,
  input  logic [DW-1:0]   cmd_imm,
  output logic [NREG-1:0] ld,
  output logic [NREG-1:0] oe,
  output logic [DW-1:0]   d,
  input  logic [DW-1:0]   p,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            err
);

`ifdef RF_SEQ_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  state_e          state, state_n;
  op_e             op_q, op_n, op_in, op_eff;
  logic [NREG-1:0] src_q, src_n, src_oh;
  logic [NREG-1:0] dst_q, dst_n, dst_oh;
  logic [DW-1:0]   imm_q, imm_n;
  logic            src_bad, dst_bad;
  logic            bad, skip, hs, acc;
  logic [NREG-1:0] ld_n, oe_n;
  logic [DW-1:0]   d_n;
  logic            err_n, rdy_n, rdv_n;

  rf_seq_dec #(.N(NREG)) u_src (
    .idx (cmd_src),
    .oh  (src_oh),
    .bad (src_bad)
  );

  rf_seq_dec #(.N(NREG)) u_dst (
    .idx (cmd_dst),
    .oh  (dst_oh),
    .bad (dst_bad)
  );

  // Bad or self-MOV commands still spend one SETUP
  // cycle but are latched as NOP so they never drive.
  always_comb begin
    op_in  = op_e'(cmd_op);
    bad    = (uses_src(op_in) & src_bad)
           | (uses_dst(op_in) & dst_bad);
    skip   = (op_in == OP_MOV)
           && (cmd_src == cmd_dst);
    op_eff = (bad || skip) ? OP_NOP : op_in;
    hs     = cmd_valid & cmd_ready;
  end

  // Outputs are registered, so everything here
  // describes the cycle after the coming edge.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    src_n   = src_q;
    dst_n   = dst_q;
    imm_n   = imm_q;
    ld_n    = '0;
    oe_n    = '0;
    d_n     = '0;
    err_n   = 1'b0;
    rdy_n   = 1'b0;
    rdv_n   = 1'b0;
    acc     = 1'b0;
    unique case (state)
      S_IDLE: begin
        rdy_n = 1'b1;
        acc   = hs;
      end
      S_SETUP: begin
        if (op_q == OP_NOP) begin
          state_n = S_IDLE;
          rdy_n   = 1'b1;
        end else begin
          state_n = S_XFER;
          rdy_n   = BURST;
          unique case (1'b1)
            op_q == OP_MOV: begin
              oe_n = src_q;
              ld_n = dst_q;
            end
            op_q == OP_LDI: begin
              d_n  = imm_q;
              ld_n = dst_q;
            end
            op_q == OP_RD: oe_n = src_q;
            default: ;
          endcase
        end
      end
      S_XFER: begin
        state_n = S_IDLE;
        rdy_n   = 1'b1;
        rdv_n   = (op_q == OP_RD);
        acc     = BURST & hs;
      end
      default: begin
        state_n = S_IDLE;
        rdy_n   = 1'b1;
      end
    endcase
    if (acc) begin
      state_n = S_SETUP;
      rdy_n   = 1'b0;
      op_n    = op_eff;
      src_n   = src_oh;
      dst_n   = dst_oh;
      imm_n   = cmd_imm;
      err_n   = bad;
      unique case (1'b1)
        op_eff == OP_MOV: oe_n = src_oh;
        op_eff == OP_RD:  oe_n = src_oh;
        op_eff == OP_LDI: d_n  = cmd_imm;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      ld        <= '0;
      oe        <= '0;
      d         <= '0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      imm_q     <= imm_n;
      ld        <= ld_n;
      oe        <= oe_n;
      d         <= d_n;
      err       <= err_n;
      cmd_ready <= rdy_n;
      rd_valid  <= rdv_n;
      if (state == S_XFER && op_q == OP_RD) begin
        rd_data <= p;
      end
    end
  end

endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq: directed + random bench for rf_seq with a
// register-file model on the bus and a frame-queue reference.
module tb_rf_seq;
  import rf_seq_pkg::*;

  localparam int DW   = 8;
  localparam int NREG = 5;

`ifdef RF_SEQ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [NREG-1:0] ld;
    logic [NREG-1:0] oe;
    logic [DW-1:0]   d;
    bit              err;
    bit              xfer;
    int              eff;
    int              s;
    int              t;
    logic [DW-1:0]   imm;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [2:0]      cmd_src;
  logic [2:0]      cmd_dst;
  logic [DW-1:0]   cmd_imm;
  logic [NREG-1:0] ld;
  logic [NREG-1:0] oe;
  logic [DW-1:0]   d;
  logic [DW-1:0]   p;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            err;

  always #5 clk = ~clk;

  rf_seq #(.DW(DW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .ld        (ld),
    .oe        (oe),
    .d         (d),
    .p         (p),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err       (err)
  );

  logic [DW-1:0] hrf [NREG];
  logic [DW-1:0] bus;
  logic          rf_init = 1'b0;

  always_comb begin
    bus = d;
    for (int i = 0; i < NREG; i++) begin
      if (oe[i]) bus = bus | hrf[i];
    end
  end
  assign p = bus;

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rf_init) hrf[i] <= '0;
      else if (ld[i]) hrf[i] <= bus;
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  frame_t        q[$];
  int            ld_at[$];
  logic [DW-1:0] mrf [NREG];
  logic [DW-1:0] m_rd;
  bit            rdv_exp;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] oh(input int i);
    logic [NREG-1:0] v;
    v = '0;
    if (i >= 0 && i < NREG) v[i] = 1'b1;
    return v;
  endfunction

  function automatic frame_t blank();
    frame_t f;
    f.ld   = '0;
    f.oe   = '0;
    f.d    = '0;
    f.err  = 1'b0;
    f.xfer = 1'b0;
    f.eff  = 0;
    f.s    = 0;
    f.t    = 0;
    f.imm  = '0;
    return f;
  endfunction

  // Expected per-cycle outputs of one accepted command.
  task automatic push_cmd(input logic [1:0] op,
                          input int s, input int t,
                          input logic [DW-1:0] im);
    frame_t f1, f2;
    bit bad;
    f1  = blank();
    f2  = blank();
    bad = ((op == OP_MOV || op == OP_RD) && s >= NREG)
       || ((op == OP_MOV || op == OP_LDI) && t >= NREG);
    if (bad) begin
      f1.err = 1'b1;
      q.push_back(f1);
    end else if (op == OP_NOP || (op == OP_MOV && s == t)) begin
      q.push_back(f1);
    end else begin
      f2.xfer = 1'b1;
      f2.s    = s;
      f2.t    = t;
      f2.imm  = im;
      case (op)
        OP_MOV: begin
          f1.oe = oh(s); f2.oe = oh(s);
          f2.ld = oh(t); f2.eff = 1;
        end
        OP_LDI: begin
          f1.d = im; f2.d = im;
          f2.ld = oh(t); f2.eff = 2;
        end
        default: begin
          f1.oe = oh(s); f2.oe = oh(s);
          f2.eff = 3;
        end
      endcase
      q.push_back(f1);
      q.push_back(f2);
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] op,
                       input int s, input int t,
                       input logic [DW-1:0] im,
                       output bit acc);
    frame_t cur, f;
    bit rdy, rdv_new;
    cmd_valid = v;
    cmd_op    = op;
    cmd_src   = 3'(s);
    cmd_dst   = 3'(t);
    cmd_imm   = im;
    if (q.size() > 0) cur = q[0];
    else cur = blank();
    rdy = (q.size() == 0)
       || (BURST && q.size() == 1 && q[0].xfer);
    chk("ready", 32'(cmd_ready), 32'(rdy));
    chk("ld", 32'(ld), 32'(cur.ld));
    chk("oe", 32'(oe), 32'(cur.oe));
    chk("d", 32'(d), 32'(cur.d));
    chk("err", 32'(err), 32'(cur.err));
    chk("rd_valid", 32'(rd_valid), 32'(rdv_exp));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    if (ld != '0) ld_at.push_back(cyc);
    rdv_new = 1'b0;
    if (q.size() > 0) begin
      f = q.pop_front();
      case (f.eff)
        1: mrf[f.t] = mrf[f.s];
        2: mrf[f.t] = f.imm;
        3: begin
          m_rd    = mrf[f.s];
          rdv_new = 1'b1;
        end
        default: ;
      endcase
    end
    rdv_exp = rdv_new;
    acc = v && rdy;
    if (acc) push_cmd(op, s, t, im);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] op,
                       input int s, input int t,
                       input logic [DW-1:0] im);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 6 && !acc; k++) begin
      cycle(1'b1, op, s, t, im, acc);
    end
    chk("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, OP_NOP, 0, 0, '0, acc);
    end
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < NREG; i++) begin
      chk(tag, 32'(hrf[i]), 32'(mrf[i]));
    end
  endtask

  initial begin
    bit            acc;
    int            s, t;
    logic [1:0]    op;
    logic [DW-1:0] im;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_imm   = '0;
    for (int i = 0; i < NREG; i++) mrf[i] = '0;
    m_rd    = '0;
    rdv_exp = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rdd", 32'(rd_data), 32'd0);
    rf_init = 1'b1;
    rst_n   = 1'b1;
    chk("rel_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;

    issue(OP_LDI, 0, int'(REG_A), 8'd100);
    idle(3);
    chk("ldi_a", 32'(hrf[0]), 32'd100);

    issue(OP_MOV, int'(REG_A), int'(REG_B), '0);
    idle(3);
    chk("mov_ab", 32'(hrf[1]), 32'd100);

    issue(OP_LDI, 0, int'(REG_C), 8'd64);
    idle(3);
    issue(OP_RD, int'(REG_C), 0, '0);
    idle(3);
    chk("rd_c", 32'(rd_data), 32'd64);

    issue(OP_MOV, 6, int'(REG_A), '0);
    idle(2);
    issue(OP_MOV, int'(REG_B), int'(REG_B), '0);
    idle(2);
    issue(OP_NOP, 0, 0, '0);
    idle(2);
    issue(OP_LDI, 0, 7, 8'd5);
    idle(2);
    issue(OP_RD, 5, 0, '0);
    idle(2);

    ld_at.delete();
    issue(OP_LDI, 0, int'(REG_D), 8'd11);
    issue(OP_LDI, 0, int'(REG_F), 8'd22);
    idle(4);
    chk("b2b_count", 32'(ld_at.size()), 32'd2);
    if (ld_at.size() == 2) begin
      chk("b2b_gap", 32'(ld_at[1] - ld_at[0]),
          BURST ? 32'd2 : 32'd3);
    end
    chk_rf("rf_dir");

    for (int n = 0; n < 400; n++) begin
      op = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 9) < 8)
         ? int'($urandom_range(0, 4))
         : int'($urandom_range(5, 7));
      t  = ($urandom_range(0, 9) < 8)
         ? int'($urandom_range(0, 4))
         : int'($urandom_range(5, 7));
      im = DW'($urandom);
      cycle(1'($urandom_range(0, 1)), op, s, t, im, acc);
    end
    idle(3);
    chk_rf("rf_rand");

    im = ~mrf[3];
    issue(OP_LDI, 0, int'(REG_D), im);
    idle(1);
    chk("xfer_ld", 32'(ld), 32'(oh(3)));
    rst_n = 1'b0;
    #1;
    chk("arst_ld", 32'(ld), 32'd0);
    chk("arst_d", 32'(d), 32'd0);
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd0);
    q.delete();
    rdv_exp = 1'b0;
    m_rd    = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arel_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    idle(2);
    chk_rf("rf_arst");

    for (int n = 0; n < 100; n++) begin
      op = 2'($urandom_range(0, 3));
      s  = int'($urandom_range(0, 5));
      t  = int'($urandom_range(0, 5));
      im = DW'($urandom);
      cycle(1'b1, op, s, t, im, acc);
    end
    idle(3);
    chk_rf("rf_end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
